// File: rtl/gpu_dispatch_pkg.sv
// Shared types for the kernel-level block dispatcher.
package gpu_dispatch_pkg;

  typedef enum logic [1:0] {
    K_IDLE,
    K_RUN,
    K_DONE
  } kernel_state_t;

  typedef enum logic [1:0] {
    C_IDLE,
    C_READY,
    C_BUSY,
    C_RESET
  } slot_state_t;

  localparam int BLOCK_ID_BITS = 8;

endpackage

// File: rtl/dispatch_slot.sv
// One dispatch slot: tracks the life of a block on a single compute core and
// produces that core's start/reset levels plus a one-cycle retire pulse.
module dispatch_slot
  import gpu_dispatch_pkg::*;
#(
  parameter int TC_BITS = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     launch,
  input  logic                     active,
  input  logic                     grant,
  input  logic [BLOCK_ID_BITS-1:0] block_id_in,
  input  logic [TC_BITS-1:0]       thread_count_in,
  input  logic                     core_done,
  output logic                     ready,
  output logic                     retire,
  output logic                     core_start,
  output logic                     core_reset,
  output logic [BLOCK_ID_BITS-1:0] block_id,
  output logic [TC_BITS-1:0]       thread_count
);

  slot_state_t state_q, state_d;
  logic        take;

  // Slot state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= C_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a kernel launch overrides everything, leaving K_RUN parks the slot.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    if (launch) begin
      state_d = C_READY;
    end else if (!active) begin
      state_d = C_IDLE;
    end else begin
      case (state_q)
        C_READY: if (grant) state_d = C_BUSY;
        C_BUSY: begin
          if (core_done) begin
            state_d = C_RESET;
            retire  = 1'b1;
          end
        end
        C_RESET: state_d = C_READY;
        default: state_d = state_q;
      endcase
    end
  end

  assign take = (state_q == C_READY) && (state_d == C_BUSY);

  // Capture the block assignment on the grant so it stays stable while busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      block_id     <= '0;
      thread_count <= '0;
    end else if (take) begin
      block_id     <= block_id_in;
      thread_count <= thread_count_in;
    end
  end

  assign ready      = (state_q == C_READY);
  assign core_start = (state_q == C_BUSY);
  assign core_reset = (state_q == C_IDLE) || (state_q == C_RESET);

endmodule

// File: rtl/block_dispatcher.sv
// Kernel scheduler: splits a launch into blocks and farms them out to free cores.
module block_dispatcher
  import gpu_dispatch_pkg::*;
#(
  parameter int NUM_CORES         = 2,
  parameter int THREADS_PER_BLOCK = 4,
  parameter int TC_BITS           = $clog2(THREADS_PER_BLOCK) + 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [7:0]                         thread_count,
  output logic                               done,
  output logic [NUM_CORES-1:0]               core_reset,
  output logic [NUM_CORES-1:0]               core_start,
  output logic [NUM_CORES*BLOCK_ID_BITS-1:0] core_block_id,
  output logic [NUM_CORES*TC_BITS-1:0]       core_thread_count,
  input  logic [NUM_CORES-1:0]               core_done
);

  localparam int TPB_SHIFT = $clog2(THREADS_PER_BLOCK);

  kernel_state_t        kstate_q, kstate_d;
  logic [7:0]           tc_q, total_q, dispatched_q, completed_q, completed_d;
  logic [8:0]           round_sum;
  logic [7:0]           total_calc, last_span;
  logic [TC_BITS-1:0]   block_tc;
  logic                 accept, launch, run, dispatch_ok;
  logic [NUM_CORES-1:0] ready, grant, retire, slot_reset;

  // Number of set bits; several cores may retire in the same cycle.
  function automatic logic [7:0] popcount(input logic [NUM_CORES-1:0] v);
    logic [7:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_CORES; i++) cnt = cnt + {7'd0, v[i]};
    return cnt;
  endfunction

  // One-hot of the lowest-index set bit.
  function automatic logic [NUM_CORES-1:0] lowest_one(input logic [NUM_CORES-1:0] v);
    logic [NUM_CORES-1:0] r;
    r = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  // Ceiling division in 9 bits so 255 threads do not wrap before the shift.
  assign round_sum  = {1'b0, thread_count} + 9'(THREADS_PER_BLOCK - 1);
  assign total_calc = 8'(round_sum >> TPB_SHIFT);

  assign run         = (kstate_q == K_RUN);
  assign dispatch_ok = run && (dispatched_q < total_q);
  assign grant       = dispatch_ok ? lowest_one(ready) : '0;
  assign completed_d = completed_q + popcount(retire);

  // The final block carries whatever threads remain; all others are full.
  assign last_span = tc_q - (dispatched_q << TPB_SHIFT);
  assign block_tc  = (dispatched_q == total_q - 8'd1) ? TC_BITS'(last_span)
                                                      : TC_BITS'(THREADS_PER_BLOCK);

  // Kernel state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) kstate_q <= K_IDLE;
    else       kstate_q <= kstate_d;
  end

  // Kernel next-state; completion looks at this cycle's retires so done follows immediately.
  always_comb begin
    kstate_d = kstate_q;
    accept   = 1'b0;
    launch   = 1'b0;
    case (kstate_q)
      K_IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (thread_count != 8'd0) begin
            launch   = 1'b1;
            kstate_d = K_RUN;
          end else begin
            kstate_d = K_DONE;
          end
        end
      end
      K_RUN:   if (completed_d == total_q) kstate_d = K_DONE;
      K_DONE:  if (!start) kstate_d = K_IDLE;
      default: kstate_d = K_IDLE;
    endcase
  end

  // Launch bookkeeping and block counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tc_q         <= '0;
      total_q      <= '0;
      dispatched_q <= '0;
      completed_q  <= '0;
    end else if (accept) begin
      tc_q         <= thread_count;
      total_q      <= total_calc;
      dispatched_q <= '0;
      completed_q  <= '0;
    end else if (run) begin
      if (|grant) dispatched_q <= dispatched_q + 8'd1;
      completed_q <= completed_d;
    end
  end

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_slot
    dispatch_slot #(
      .TC_BITS(TC_BITS)
    ) u_slot (
      .clk            (clk),
      .reset          (reset),
      .launch         (launch),
      .active         (run),
      .grant          (grant[i]),
      .block_id_in    (dispatched_q),
      .thread_count_in(block_tc),
      .core_done      (core_done[i]),
      .ready          (ready[i]),
      .retire         (retire[i]),
      .core_start     (core_start[i]),
      .core_reset     (slot_reset[i]),
      .block_id       (core_block_id[i*BLOCK_ID_BITS +: BLOCK_ID_BITS]),
      .thread_count   (core_thread_count[i*TC_BITS +: TC_BITS])
    );
  end

  assign core_reset = slot_reset | {NUM_CORES{!run}};
  assign done       = (kstate_q == K_DONE);

endmodule

// File: tb/tb_block_dispatcher.sv
// Directed bench for block_dispatcher (NUM_CORES=2, THREADS_PER_BLOCK=4).
module tb_block_dispatcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  thread_count;
  logic        done;
  logic [1:0]  core_reset;
  logic [1:0]  core_start;
  logic [15:0] core_block_id;
  logic [5:0]  core_thread_count;
  logic [1:0]  core_done;
  logic [1:0]  echo_done;
  logic [1:0]  force_done;
  logic        echo_en;
  int          echo_cnt [2];
  int          errors = 0;
  int          checks = 0;

  assign core_done = echo_done | force_done;

  block_dispatcher #(
    .NUM_CORES(2),
    .THREADS_PER_BLOCK(4),
    .TC_BITS(3)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .thread_count     (thread_count),
    .done             (done),
    .core_reset       (core_reset),
    .core_start       (core_start),
    .core_block_id    (core_block_id),
    .core_thread_count(core_thread_count),
    .core_done        (core_done)
  );

  always #5 clk = ~clk;

  // Core model: raise done on the fifth falling edge of a core_start level.
  initial begin
    echo_done = 2'b00;
    echo_cnt[0] = 0;
    echo_cnt[1] = 0;
  end
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!echo_en || !core_start[i]) begin
        echo_cnt[i]  = 0;
        echo_done[i] = 1'b0;
      end else if (echo_cnt[i] < 5) begin
        echo_cnt[i] = echo_cnt[i] + 1;
        if (echo_cnt[i] == 5) echo_done[i] = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; thread_count = 8'd0; force_done = 2'b00; echo_en = 1'b0;
    tick(); tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (core_start !== 2'b00) begin errors++; $display("FAIL reset_core_start: got %b expected 00", core_start); end
    checks++; if (core_reset !== 2'b11) begin errors++; $display("FAIL reset_core_reset: got %b expected 11", core_reset); end
    checks++; if (core_block_id !== 16'h0000) begin errors++; $display("FAIL reset_block_id: got %h expected 0000", core_block_id); end
    checks++; if (core_thread_count !== 6'd0) begin errors++; $display("FAIL reset_thread_count: got %h expected 00", core_thread_count); end
    reset = 1'b0;
    tick();
    checks++; if (core_reset !== 2'b11) begin errors++; $display("FAIL idle_core_reset: got %b expected 11", core_reset); end
  endtask

  // 8 threads -> two full blocks, cores echo done.
  task automatic test_two_blocks();
    echo_en = 1'b1; thread_count = 8'd8; start = 1'b1;
    tick(); // E0: launch accepted, slots ready
    checks++; if (core_start !== 2'b00 || core_reset !== 2'b00) begin errors++; $display("FAIL tb_e0: got start=%b reset=%b expected 00/00", core_start, core_reset); end
    tick(); // E1: block 0 -> core 0
    checks++; if (core_start !== 2'b01) begin errors++; $display("FAIL tb_first_start: got %b expected 01", core_start); end
    checks++; if (core_block_id[7:0] !== 8'd0 || core_thread_count[2:0] !== 3'd4) begin errors++; $display("FAIL tb_core0_assign: got id=%0d tc=%0d expected 0/4", core_block_id[7:0], core_thread_count[2:0]); end
    tick(); // E2: block 1 -> core 1
    checks++; if (core_start !== 2'b11) begin errors++; $display("FAIL tb_second_start: got %b expected 11", core_start); end
    checks++; if (core_block_id[15:8] !== 8'd1 || core_thread_count[5:3] !== 3'd4) begin errors++; $display("FAIL tb_core1_assign: got id=%0d tc=%0d expected 1/4", core_block_id[15:8], core_thread_count[5:3]); end
    tick(); tick(); tick();
    tick(); // E6: core 0 retires
    checks++; if (done !== 1'b0 || core_start !== 2'b10) begin errors++; $display("FAIL tb_core0_retire: got done=%b start=%b expected 0/10", done, core_start); end
    tick(); // E7: core 1 retires, kernel complete
    checks++; if (done !== 1'b1 || core_reset !== 2'b11) begin errors++; $display("FAIL tb_done: got done=%b reset=%b expected 1/11", done, core_reset); end
    start = 1'b0; echo_en = 1'b0;
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL tb_done_clear: got %b expected 0", done); end
  endtask

  // 10 threads -> 4/4/2; block 2 reuses the first core to retire.
  task automatic test_partial_block();
    echo_en = 1'b1; thread_count = 8'd10; start = 1'b1;
    tick(); tick();
    tick(); // E2
    checks++; if (core_start !== 2'b11) begin errors++; $display("FAIL pb_both_start: got %b expected 11", core_start); end
    tick(); tick(); tick();
    tick(); // E6: core 0 in its reset cycle
    checks++; if (core_reset !== 2'b01 || core_start !== 2'b10) begin errors++; $display("FAIL pb_core0_reset: got reset=%b start=%b expected 01/10", core_reset, core_start); end
    tick(); // E7: core 0 ready, core 1 in reset
    checks++; if (core_reset !== 2'b10 || core_start !== 2'b00) begin errors++; $display("FAIL pb_core0_ready: got reset=%b start=%b expected 10/00", core_reset, core_start); end
    tick(); // E8: block 2 on core 0
    checks++; if (core_start !== 2'b01) begin errors++; $display("FAIL pb_block2_start: got %b expected 01", core_start); end
    checks++; if (core_block_id[7:0] !== 8'd2 || core_thread_count[2:0] !== 3'd2) begin errors++; $display("FAIL pb_block2_assign: got id=%0d tc=%0d expected 2/2", core_block_id[7:0], core_thread_count[2:0]); end
    tick(); // E9: core 1 ready but nothing left to dispatch
    checks++; if (core_start !== 2'b01 || core_reset !== 2'b00) begin errors++; $display("FAIL pb_no_extra: got start=%b reset=%b expected 01/00", core_start, core_reset); end
    tick(); tick();
    tick(); // E12
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL pb_early_done: got %b expected 0", done); end
    tick(); // E13: last retire
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL pb_done: got %b expected 1", done); end
    start = 1'b0; echo_en = 1'b0;
    tick();
  endtask

  task automatic test_zero_threads();
    thread_count = 8'd0; start = 1'b1;
    tick();
    checks++; if (core_start !== 2'b00) begin errors++; $display("FAIL zero_no_start_e0: got %b expected 00", core_start); end
    tick();
    checks++; if (done !== 1'b1 || core_start !== 2'b00 || core_reset !== 2'b11) begin errors++; $display("FAIL zero_done: got done=%b start=%b reset=%b expected 1/00/11", done, core_start, core_reset); end
    start = 1'b0;
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_clear: got %b expected 0", done); end
  endtask

  // 16 threads, both cores finish together.
  task automatic test_simultaneous_done();
    thread_count = 8'd16; start = 1'b1;
    tick(); tick();
    tick(); // E2
    checks++; if (core_start !== 2'b11) begin errors++; $display("FAIL sim_both_start: got %b expected 11", core_start); end
    tick(); // E3
    force_done = 2'b11;
    tick(); // E4: both retire
    checks++; if (dut.completed_q !== 8'd2) begin errors++; $display("FAIL sim_completed: got %0d expected 2", dut.completed_q); end
    checks++; if (core_start !== 2'b00 || core_reset !== 2'b11) begin errors++; $display("FAIL sim_both_reset: got start=%b reset=%b expected 00/11", core_start, core_reset); end
    force_done = 2'b00;
    tick(); // E5: both ready
    tick(); // E6: block 2 -> core 0
    checks++; if (core_start !== 2'b01 || core_block_id[7:0] !== 8'd2) begin errors++; $display("FAIL sim_block2: got start=%b id=%0d expected 01/2", core_start, core_block_id[7:0]); end
    tick(); // E7: block 3 -> core 1
    checks++; if (core_start !== 2'b11 || core_block_id[15:8] !== 8'd3 || core_thread_count[5:3] !== 3'd4) begin errors++; $display("FAIL sim_block3: got start=%b id=%0d tc=%0d expected 11/3/4", core_start, core_block_id[15:8], core_thread_count[5:3]); end
    force_done = 2'b11;
    tick(); // E8
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL sim_done: got %b expected 1", done); end
    force_done = 2'b00; start = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_kernel();
    thread_count = 8'd16; start = 1'b1;
    tick(); tick(); tick();
    checks++; if (core_start !== 2'b11) begin errors++; $display("FAIL rst_pre: got %b expected 11", core_start); end
    #2;
    reset = 1'b1; start = 1'b0;
    #1;
    checks++; if (core_start !== 2'b00 || core_reset !== 2'b11 || done !== 1'b0) begin errors++; $display("FAIL rst_async: got start=%b reset=%b done=%b expected 00/11/0", core_start, core_reset, done); end
    tick();
    reset = 1'b0;
    tick();
    thread_count = 8'd4; start = 1'b1;
    tick(); tick(); // E1
    checks++; if (core_start !== 2'b01 || core_block_id[7:0] !== 8'd0 || core_thread_count[2:0] !== 3'd4) begin errors++; $display("FAIL rst_relaunch: got start=%b id=%0d tc=%0d expected 01/0/4", core_start, core_block_id[7:0], core_thread_count[2:0]); end
    tick(); // E2
    checks++; if (core_start !== 2'b01) begin errors++; $display("FAIL rst_core1_unused: got %b expected 01", core_start); end
    force_done = 2'b01;
    tick();
    checks++; if (done !== 1'b1 || core_start !== 2'b00) begin errors++; $display("FAIL rst_done: got done=%b start=%b expected 1/00", done, core_start); end
    force_done = 2'b00; start = 1'b0;
    tick();
  endtask

  task automatic test_spurious_inputs();
    thread_count = 8'd4; start = 1'b1;
    tick(); tick(); // E1
    start = 1'b0; force_done = 2'b10;
    tick(); // E2: start low and done on a non-busy core are both ignored
    checks++; if (dut.dispatched_q !== 8'd1 || dut.completed_q !== 8'd0) begin errors++; $display("FAIL spur_counters: got disp=%0d comp=%0d expected 1/0", dut.dispatched_q, dut.completed_q); end
    checks++; if (done !== 1'b0 || core_start !== 2'b01) begin errors++; $display("FAIL spur_state: got done=%b start=%b expected 0/01", done, core_start); end
    force_done = 2'b00; start = 1'b1;
    tick();
    force_done = 2'b01;
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL spur_done: got %b expected 1", done); end
    force_done = 2'b00; start = 1'b0;
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL spur_done_clear: got %b expected 0", done); end
  endtask

  initial begin
    force_done = 2'b00;
    echo_en = 1'b0;
    test_reset();
    test_two_blocks();
    test_partial_block();
    test_zero_threads();
    test_simultaneous_done();
    test_reset_mid_kernel();
    test_spurious_inputs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within 100000 time units");
    $fatal(1, "timeout");
  end

endmodule
